// File: rtl/frame_buf_wr.sv
// frame_buf_wr: drains a pixel FIFO (one-cycle read latency) into a
// single- or double-banked frame buffer in BRAM. Frames are delimited by an
// SOF tag on their first pixel; short frames restart in place and overlong
// frames are truncated and resynchronised.
module frame_buf_wr #(
    parameter int  DATA_W    = 12,
    parameter int  ROWLENGTH = 640,
    parameter int  NUM_ROWS  = 480,
    parameter int  NUM_BANKS = 2,
    localparam int FRAME_PIX = ROWLENGTH * NUM_ROWS,
    localparam int AW        = $clog2(NUM_BANKS * FRAME_PIX)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    output logic              o_rd,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_sof,
    input  logic              i_empty,
    output logic [AW-1:0]     o_waddr,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_wr,
    output logic              o_frame_done,
    output logic              o_done_bank,
    output logic              o_short_err,
    output logic              o_long_err
);

    // Width of the in-frame pixel offset.
    localparam int PW = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        ACTIVE
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            rd_valid;   // FIFO word is on i_data/i_sof this cycle
    logic [PW-1:0]   pix;        // offset of the last pixel written
    logic            full;       // last write closed the frame
    logic            bank;       // bank currently being written

    logic            do_wr;
    logic [PW-1:0]   wr_off;
    logic            wr_last;
    logic            set_short;
    logic            set_long;
    logic [AW-1:0]   waddr_nxt;

    // Read whenever capture is enabled, the FSM is out of IDLE and data exists.
    assign o_rd = (state != IDLE) && !i_empty && i_en;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            state <= state_nxt;
        end
    end

    // Decide what the consumed word does and where the FSM goes next.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nxt = state;
        do_wr     = 1'b0;
        wr_off    = '0;
        set_short = 1'b0;
        set_long  = 1'b0;

        if (rd_valid) begin
            unique case (state)
                SYNC: begin
                    // Hunt for the start of a frame; everything else is noise.
                    if (i_sof) begin
                        do_wr     = 1'b1;
                        state_nxt = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (i_sof) begin
                        // New frame; early if the previous one never closed.
                        do_wr     = 1'b1;
                        set_short = !full;
                    end else if (full) begin
                        // Frame already complete: drop the extra pixel.
                        set_long  = 1'b1;
                        state_nxt = SYNC;
                    end else begin
                        do_wr  = 1'b1;
                        wr_off = pix + 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (state == IDLE && i_en) begin
            state_nxt = SYNC;
        end
        // Disable wins over anything the in-flight word requested.
        if (!i_en) begin
            state_nxt = IDLE;
        end
    end

    assign wr_last   = do_wr && (wr_off == PW'(FRAME_PIX - 1));
    assign waddr_nxt = (bank ? AW'(FRAME_PIX) : AW'(0)) + AW'(wr_off);

    // Read pipeline, frame position, bank rotation and registered BRAM port.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_valid     <= 1'b0;
            pix          <= '0;
            full         <= 1'b0;
            bank         <= 1'b0;
            o_wr         <= 1'b0;
            o_waddr      <= '0;
            o_wdata      <= '0;
            o_frame_done <= 1'b0;
            o_done_bank  <= 1'b0;
            o_short_err  <= 1'b0;
            o_long_err   <= 1'b0;
        end else begin
            rd_valid     <= o_rd;
            o_wr         <= do_wr;
            o_frame_done <= wr_last;
            o_short_err  <= set_short;
            o_long_err   <= set_long;

            if (do_wr) begin
                pix     <= wr_off;
                full    <= wr_last;
                o_waddr <= waddr_nxt;
                o_wdata <= i_data;
            end

            if (wr_last) begin
                o_done_bank <= bank;
                if (NUM_BANKS == 2) begin
                    bank <= ~bank;
                end
            end
        end
    end

    // Address and offset never leave the buffer; FIFO never read while empty.
    a_addr_range : assert property (@(posedge i_clk) disable iff (i_rst)
        o_wr |-> (o_waddr <= AW'(NUM_BANKS * FRAME_PIX - 1)));
    a_pix_range : assert property (@(posedge i_clk) disable iff (i_rst)
        pix <= PW'(FRAME_PIX - 1));
    a_no_empty_rd : assert property (@(posedge i_clk) disable iff (i_rst)
        !(o_rd && i_empty));

endmodule

// File: tb/tb_frame_buf_wr.sv
// tb_frame_buf_wr: directed vector table for the frame-level scenarios, a
// reset-during-frame sequence with a stuttering FIFO, then random traffic
// checked against a frame-level behavioural model.
module tb_frame_buf_wr;

    localparam int DW = 12;
    localparam int RL = 4;
    localparam int NR = 2;
    localparam int NB = 2;
    localparam int FP = RL * NR;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          rd;
    logic [DW-1:0] idata;
    logic          sof;
    logic          empty;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          wr;
    logic          fdone;
    logic          dbank;
    logic          serr;
    logic          lerr;

    always #5 clk = ~clk;

    frame_buf_wr #(
        .DATA_W   (DW),
        .ROWLENGTH(RL),
        .NUM_ROWS (NR),
        .NUM_BANKS(NB)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .o_rd        (rd),
        .i_data      (idata),
        .i_sof       (sof),
        .i_empty     (empty),
        .o_waddr     (waddr),
        .o_wdata     (wdata),
        .o_wr        (wr),
        .o_frame_done(fdone),
        .o_done_bank (dbank),
        .o_short_err (serr),
        .o_long_err  (lerr)
    );

    typedef struct packed {
        logic          sof;
        logic [DW-1:0] data;
    } word_t;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          done;
        logic          dbank;
        logic          serr;
        logic          lerr;
    } exp_t;

    typedef struct packed {
        logic  start;   // reset the DUT before this word
        word_t w;
        exp_t  e;
    } vec_t;

    vec_t  vecs[$];
    word_t fifo[$];
    exp_t  exp_q[$];

    int    checks = 0;
    int    errors = 0;

    logic  inflight_v = 1'b0;
    word_t inflight_w;
    logic  en_seen    = 1'b0;   // DUT is out of IDLE
    logic  use_model  = 1'b0;
    logic  toggle_empty = 1'b0;
    logic  rand_gap   = 1'b0;
    logic  phase      = 1'b0;
    logic  exp_dbank  = 1'b0;

    // Frame-level reference model state.
    logic  m_synced;
    int    m_cnt;
    int    m_bank;
    logic  m_dbank;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // One consumed FIFO word, applied to the frame rules.
    function automatic exp_t model_consume(input word_t w);
        exp_t e;
        int   off;
        e       = '0;
        e.dbank = m_dbank;
        off     = -1;
        if (!m_synced) begin
            if (w.sof) begin
                off      = 0;
                m_synced = 1'b1;
            end
        end else if (w.sof) begin
            e.serr = (m_cnt < FP);
            off    = 0;
        end else if (m_cnt == FP) begin
            e.lerr   = 1'b1;
            m_synced = 1'b0;
        end else begin
            off = m_cnt;
        end
        if (off >= 0) begin
            e.wr   = 1'b1;
            e.addr = AW'(m_bank * FP + off);
            e.data = w.data;
            m_cnt  = off + 1;
            if (m_cnt == FP) begin
                e.done  = 1'b1;
                m_dbank = m_bank[0];
                e.dbank = m_bank[0];
                m_bank  = (m_bank + 1) % NB;
            end
        end
        return e;
    endfunction

    // One clock: check o_rd, take the edge, check the write port, feed the FIFO.
    task automatic step();
        logic rd_s;
        exp_t e;
        @(negedge clk);
        rd_s = rd;
        check("o_rd", {31'd0, rd}, {31'd0, en_seen && !empty && en});
        @(posedge clk);
        e       = '0;
        e.dbank = exp_dbank;
        if (inflight_v) begin
            if (use_model) begin
                e = model_consume(inflight_w);
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
            end else begin
                checks++;
                errors++;
                $display("FAIL exp_underflow: got a word with no expectation at %0t", $time);
            end
        end
        exp_dbank = e.dbank;
        if (!en) m_synced = 1'b0;
        en_seen = en;
        #1;
        check("flags{wr,done,serr,lerr,dbank}", {27'd0, wr, fdone, serr, lerr, dbank},
              {27'd0, e.wr, e.done, e.serr, e.lerr, e.dbank});
        if (e.wr) begin
            check("waddr", {28'd0, waddr}, {28'd0, e.addr});
            check("wdata", {20'd0, wdata}, {20'd0, e.data});
        end
        if (rd_s && fifo.size() > 0) begin
            inflight_w = fifo.pop_front();
            inflight_v = 1'b1;
            idata      = inflight_w.data;
            sof        = inflight_w.sof;
        end else begin
            inflight_v = 1'b0;
            idata      = DW'($urandom);
            sof        = 1'($urandom);
        end
        phase = ~phase;
        empty = (fifo.size() == 0) || (toggle_empty && phase) ||
                (rand_gap && ($urandom_range(3) == 0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_flags{wr,done,serr,lerr,dbank,rd}", {26'd0, wr, fdone, serr, lerr, dbank, rd}, 32'd0);
        check("rst_waddr", {28'd0, waddr}, 32'd0);
        check("rst_wdata", {20'd0, wdata}, 32'd0);
        fifo.delete();
        exp_q.delete();
        inflight_v = 1'b0;
        en_seen    = 1'b0;
        exp_dbank  = 1'b0;
        m_synced   = 1'b0;
        m_cnt      = 0;
        m_bank     = 0;
        m_dbank    = 1'b0;
        empty      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((fifo.size() > 0 || inflight_v) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d words left after %0d cycles", fifo.size(), budget);
        end
        step();
    endtask

    task automatic add(input logic start, input logic s, input int d, input logic w,
                       input int a, input logic dn, input logic db, input logic se, input logic le);
        vec_t v;
        v         = '0;
        v.start   = start;
        v.w.sof   = s;
        v.w.data  = DW'(d);
        v.e.wr    = w;
        v.e.addr  = AW'(a);
        v.e.data  = DW'(d);
        v.e.done  = dn;
        v.e.dbank = db;
        v.e.serr  = se;
        v.e.lerr  = le;
        vecs.push_back(v);
    endtask

    // Clean SOF-led frame into bank b; db is o_done_bank before it completes.
    task automatic add_frame(input logic start, input int base, input int b, input logic db);
        for (int i = 0; i < FP; i++) begin
            add(start && (i == 0), i == 0, base + i, 1'b1, b * FP + i,
                i == FP - 1, (i == FP - 1) ? b[0] : db, 1'b0, 1'b0);
        end
    endtask

    task automatic push_frame(input int base, input int b);
        word_t w;
        exp_t  e;
        for (int i = 0; i < FP; i++) begin
            w.sof  = (i == 0);
            w.data = DW'(base + i);
            e      = '0;
            e.wr   = 1'b1;
            e.addr = AW'(b * FP + i);
            e.data = w.data;
            e.done = (i == FP - 1);
            e.dbank = (i == FP - 1) ? b[0] : 1'b0;
            fifo.push_back(w);
            exp_q.push_back(e);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        word_t w;
        int    n;

        rst   = 1'b0;
        en    = 1'b0;
        empty = 1'b1;
        idata = '0;
        sof   = 1'b0;

        // Three back-to-back frames: banks 0, 1, 0.
        add_frame(1'b1, 'h001, 0, 1'b0);
        add_frame(1'b0, 'h011, 1, 1'b0);
        add_frame(1'b0, 'h021, 0, 1'b1);
        // Leading non-SOF words are dropped before the first frame.
        add(1'b1, 1'b0, 'h0A1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 'h0A2, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_frame(1'b0, 'h0B1, 0, 1'b0);
        // Short frame: SOF after 4 pixels restarts bank 0 at pixel 0.
        add(1'b1, 1'b1, 'h0C1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 4; i++) add(1'b0, 1'b0, 'h0C1 + i, 1'b1, i, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 'h0D1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i < FP; i++) add(1'b0, 1'b0, 'h0D1 + i, 1'b1, i, i == FP - 1, 1'b0, 1'b0, 1'b0);
        // Overlong frame: extra pixel dropped with an error, next SOF in bank 1.
        add_frame(1'b1, 'h0E1, 0, 1'b0);
        add(1'b0, 1'b0, 'h0F0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 'h101, 1'b1, 8, 1'b0, 1'b0, 1'b0, 1'b0);

        #2;
        en = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].start) begin
                drain(200);
                do_reset();
            end
            fifo.push_back(vecs[i].w);
            exp_q.push_back(vecs[i].e);
        end
        drain(200);

        // Stuttering FIFO, reset at pixel 5, then a fresh frame lands at 0.
        do_reset();
        toggle_empty = 1'b1;
        push_frame('h201, 0);
        n = 0;
        while (!(wr && waddr == AW'(5)) && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL pix5_timeout: no write at address 5 within 100 cycles");
        end
        do_reset();
        push_frame('h301, 0);
        drain(200);
        toggle_empty = 1'b0;

        // Random traffic against the frame-level model.
        use_model = 1'b1;
        rand_gap  = 1'b1;
        en        = 1'b1;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (fifo.size() < 3 && $urandom_range(3) != 0) begin
                w.sof  = ($urandom_range(9) == 0);
                w.data = DW'($urandom);
                fifo.push_back(w);
            end
            if (en && $urandom_range(99) < 2) en = 1'b0;
            else if (!en && $urandom_range(4) == 0) en = 1'b1;
            step();
        end
        en = 1'b1;
        drain(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_buf_wr.md
FRAME_BUF_WR -- requirements
Module: frame_buf_wr

Interface
REQ-001 SHALL have parameter DATA_W, default 12, pixel width in bits.
REQ-002 SHALL have parameter ROWLENGTH, default 640, pixels per row.
REQ-003 SHALL have parameter NUM_ROWS, default 480, rows per frame; FRAME_PIX = ROWLENGTH*NUM_ROWS.
REQ-004 SHALL have parameter NUM_BANKS, default 2, frame banks (legal values 1 or 2); AW = $clog2(NUM_BANKS*FRAME_PIX).
REQ-005 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port i_rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have port i_en  input  1  capture enable.
REQ-008 SHALL have port o_rd  output  1  FIFO read strobe; data returns one cycle later.
REQ-009 SHALL have port i_data  input  DATA_W  FIFO pixel data.
REQ-010 SHALL have port i_sof  input  1  FIFO start-of-frame tag, same timing as i_data.
REQ-011 SHALL have port i_empty  input  1  FIFO empty.
REQ-012 SHALL have port o_waddr  output  AW  BRAM write address.
REQ-013 SHALL have port o_wdata  output  DATA_W  BRAM write data.
REQ-014 SHALL have port o_wr  output  1  BRAM write enable.
REQ-015 SHALL have port o_frame_done  output  1  one-cycle pulse on last pixel write of a frame.
REQ-016 SHALL have port o_done_bank  output  1  bank holding the most recent complete frame.
REQ-017 SHALL have port o_short_err  output  1  one-cycle pulse on early SOF.
REQ-018 SHALL have port o_long_err  output  1  one-cycle pulse on overlong frame.

Function
REQ-019 SHALL implement states IDLE, SYNC, ACTIVE; IDLE->SYNC when i_en=1; SYNC/ACTIVE->IDLE when i_en=0.
REQ-020 SHALL drive o_rd = (state != IDLE) && !i_empty && i_en, combinationally; never read while i_empty=1.
REQ-021 SHALL register rd_valid = o_rd; word (i_data, i_sof) is consumed in the cycle rd_valid=1, including a word in flight when i_en falls.
REQ-022 SYNC: SHALL discard non-SOF words; SOF word SHALL be written at pixel 0 of the current write bank, state->ACTIVE.
REQ-023 ACTIVE, non-SOF word, pixel count < FRAME_PIX: SHALL write at next pixel offset.
REQ-024 Write SHALL be registered: o_wr=1, o_wdata=i_data, o_waddr=bank*FRAME_PIX+pix, one cycle after the consuming cycle (two cycles after o_rd).
REQ-025 Write of pixel FRAME_PIX-1 SHALL coincide with o_frame_done=1 and o_done_bank=current bank; write bank SHALL then toggle when NUM_BANKS=2.
REQ-026 ACTIVE, SOF word before pixel FRAME_PIX-1 written: SHALL pulse o_short_err, restart at pixel 0 of the same bank, write the word, no bank toggle, no o_frame_done.
REQ-027 After a complete frame, a non-SOF word SHALL be discarded, o_long_err pulsed, state->SYNC; an SOF word SHALL start the next frame at pixel 0 normally.
REQ-028 Error pulses SHALL coincide with the o_wr cycle of the affected word (or the would-be write cycle if discarded).
REQ-029 Pixel counter SHALL never exceed FRAME_PIX-1; address SHALL never exceed NUM_BANKS*FRAME_PIX-1.
REQ-030 Re-entry from IDLE SHALL always pass through SYNC; bank selection persists across IDLE.

Reset
REQ-031 On i_rst=1, asynchronously: state=IDLE, o_wr=0, o_waddr=0, o_wdata=0, o_frame_done=0, o_short_err=0, o_long_err=0, o_done_bank=0, write bank=0, pixel count=0, rd_valid=0.
REQ-032 Reset mid-frame SHALL abandon the frame; no write or pulse in the cycle reset deasserts.

Verification (ROWLENGTH=4, NUM_ROWS=2, NUM_BANKS=2, FRAME_PIX=8)
REQ-033 Reset, i_en=1, 8 words (first SOF) data 0x001..0x008 -> writes addr 0..7, o_frame_done with addr 7, o_done_bank=0.
REQ-034 Second 8-word SOF frame -> writes addr 8..15, o_frame_done at addr 15, o_done_bank=1; third frame -> addr 0..7.
REQ-035 Two non-SOF words then SOF frame after reset -> first two words discarded (no o_wr), SOF written at addr 0.
REQ-036 SOF, 3 words, SOF, 7 words -> o_short_err with second SOF write at addr 0, frame completes at addr 7, bank 0.
REQ-037 Complete frame then non-SOF word -> no write, o_long_err pulse, next SOF written at addr 8.
REQ-038 i_empty toggling every cycle and i_rst asserted at pixel 5 -> no o_rd while empty, all outputs 0 immediately, next SOF written at addr 0.
